// File: rtl/mul_seq.sv
// mul_seq: sequential 16x16 multiply job driven through a byte-wide
// multiplier port. A job writes four operand bytes (AH, AL, BH, BL), then
// reads four product bytes (P[31:24] first). Read data returns RD_LAT
// clocks after the read strobe is sampled.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        job request (IDLE only) / cancel (WR, RD only)
//   op_a, op_b          16-bit operands, latched on the accepting edge
//   busy, done, result  status, one-cycle done pulse, last product
//   mul_wr_en/sel/data  operand byte write port
//   mul_rd_en/sel/data  product byte read port
module mul_seq #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        mul_wr_en,
  output logic [1:0]  mul_wr_sel,
  output logic [7:0]  mul_wr_data,
  output logic        mul_rd_en,
  output logic [1:0]  mul_rd_sel,
  input  logic [7:0]  mul_rd_data
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_e;

  localparam logic [2:0] LAT3    = 3'(RD_LAT);
  localparam logic [2:0] RD_LAST = 3'(3 + RD_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [1:0]  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [1:0]  rd_byte;

  // Product byte index being returned this cycle (valid once cnt >= RD_LAT).
  assign rd_byte = 2'(cnt_q - LAT3);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = op_a;
        b_d     = op_b;
        cnt_d   = 3'd0;
        state_d = WR;
      end
      WR: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd3) begin
          state_d = RD;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q >= LAT3) begin
            case (rd_byte)
              2'd0: shadow_d[31:24] = mul_rd_data;
              2'd1: shadow_d[23:16] = mul_rd_data;
              2'd2: shadow_d[15:8]  = mul_rd_data;
              default: shadow_d[7:0] = mul_rd_data;
            endcase
          end
          if (cnt_q == RD_LAST) begin
            // Result moves as a whole, including the byte captured this edge.
            state_d  = DONE;
            cnt_d    = 3'd0;
            result_d = shadow_d;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they describe.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    wr_en_d   = (state_d == WR);
    rd_en_d   = (state_d == RD) && (cnt_d <= 3'd3);
    wr_sel_d  = wr_en_d ? cnt_d[1:0] : 2'd0;
    rd_sel_d  = rd_en_d ? cnt_d[1:0] : 2'd0;
    wr_data_d = 8'd0;
    if (wr_en_d) begin
      case (cnt_d[1:0])
        2'd0:    wr_data_d = a_d[15:8];
        2'd1:    wr_data_d = a_d[7:0];
        2'd2:    wr_data_d = b_d[15:8];
        default: wr_data_d = b_d[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      shadow_q  <= 32'd0;
      result_q  <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_sel_q  <= 2'd0;
      rd_sel_q  <= 2'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      shadow_q  <= shadow_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign mul_wr_en   = wr_en_q;
  assign mul_wr_sel  = wr_sel_q;
  assign mul_wr_data = wr_data_q;
  assign mul_rd_en   = rd_en_q;
  assign mul_rd_sel  = rd_sel_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: two instances (RD_LAT=1 and RD_LAT=3), each with a
// byte-port multiplier model. Stimulus pushes expected jobs into a queue;
// a monitor per instance checks write bytes, done latency and result.
module tb_mul_seq;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          t;
  } job_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [2];
  logic        abort_s [2];
  logic [15:0] opa [2];
  logic [15:0] opb [2];
  logic        busy_s [2];
  logic        done_s [2];
  logic [31:0] res_s [2];
  logic        wr_en_s [2];
  logic [1:0]  wr_sel_s [2];
  logic [7:0]  wr_data_s [2];
  logic        rd_en_s [2];
  logic [1:0]  rd_sel_s [2];
  logic [7:0]  rd_data_s [2];

  job_t        sbq [2][$];
  logic [31:0] last_res [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    mul_seq #(.RD_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_s[g]), .abort(abort_s[g]),
      .op_a(opa[g]), .op_b(opb[g]), .busy(busy_s[g]), .done(done_s[g]),
      .result(res_s[g]), .mul_wr_en(wr_en_s[g]), .mul_wr_sel(wr_sel_s[g]),
      .mul_wr_data(wr_data_s[g]), .mul_rd_en(rd_en_s[g]),
      .mul_rd_sel(rd_sel_s[g]), .mul_rd_data(rd_data_s[g])
    );

    // Multiplier model: operand byte registers, product read with LAT delay.
    logic [7:0]  ah = 0, al = 0, bh = 0, bl = 0;
    logic [7:0]  pipe [LAT];
    logic [31:0] prod;
    logic [7:0]  rbyte;
    assign prod = {16'd0, ah, al} * {16'd0, bh, bl};
    always_comb begin
      case (rd_sel_s[g])
        2'd0:    rbyte = prod[31:24];
        2'd1:    rbyte = prod[23:16];
        2'd2:    rbyte = prod[15:8];
        default: rbyte = prod[7:0];
      endcase
    end
    always @(posedge clk) begin
      if (wr_en_s[g]) begin
        case (wr_sel_s[g])
          2'd0:    ah <= wr_data_s[g];
          2'd1:    al <= wr_data_s[g];
          2'd2:    bh <= wr_data_s[g];
          default: bl <= wr_data_s[g];
        endcase
      end
      pipe[0] <= rd_en_s[g] ? rbyte : 8'h00;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rd_data_s[g] = pipe[LAT-1];

    // Monitor / scoreboard.
    always @(negedge clk) begin
      job_t        j;
      logic [31:0] ops;
      logic [7:0]  eb;
      if (rst_n) begin
        chk($sformatf("idle_sel%0d", g),
            {62'd0, !wr_en_s[g] && (wr_sel_s[g] != 0 || wr_data_s[g] != 0),
             !rd_en_s[g] && rd_sel_s[g] != 0}, 64'd0);
        chk($sformatf("strobe_nobusy%0d", g),
            {63'd0, !busy_s[g] && (wr_en_s[g] || rd_en_s[g] || done_s[g])}, 64'd0);
        if (wr_en_s[g] && sbq[g].size() > 0) begin
          ops = {sbq[g][0].a, sbq[g][0].b};
          case (wr_sel_s[g])
            2'd0:    eb = ops[31:24];
            2'd1:    eb = ops[23:16];
            2'd2:    eb = ops[15:8];
            default: eb = ops[7:0];
          endcase
          chk($sformatf("wr_byte%0d_sel%0d", g, wr_sel_s[g]), {56'd0, wr_data_s[g]}, {56'd0, eb});
        end
        if (done_s[g]) begin
          if (sbq[g].size() == 0) begin
            chk($sformatf("unexpected_done%0d", g), 64'd1, 64'd0);
          end else begin
            j = sbq[g].pop_front();
            last_res[g] = 32'(j.a * j.b);
            chk($sformatf("result%0d", g), {32'd0, res_s[g]}, {32'd0, last_res[g]});
            chk($sformatf("latency%0d", g), 64'(cyc - j.t), 64'(8 + LAT));
          end
        end
      end
    end
  end

  // Drive a start from the current (negedge) point; returns #1 after the start edge.
  task automatic do_job(input int i, input logic [15:0] a, input logic [15:0] b, input bit expect_done);
    job_t j;
    start_s[i] = 1'b1;
    opa[i] = a;
    opb[i] = b;
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    abort_s[i] = 1'b0;
    opa[i] = 16'($urandom);
    opb[i] = 16'($urandom);
    j.a = a; j.b = b; j.t = cyc;
    if (expect_done) sbq[i].push_back(j);
    chk($sformatf("busy_after_start%0d", i), {63'd0, busy_s[i]}, 64'd1);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk);
    while (busy_s[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy_s[i]) chk($sformatf("timeout%0d", i), 64'd1, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 0; abort_s[i] = 0; opa[i] = 0; opb[i] = 0; last_res[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_out%0d", i),
          {busy_s[i], done_s[i], wr_en_s[i], rd_en_s[i], wr_sel_s[i], rd_sel_s[i], wr_data_s[i], res_s[i]},
          64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed jobs, RD_LAT=1.
    do_job(0, 16'h1234, 16'h5678, 1); wait_idle(0);
    chk("res_1234x5678", {32'd0, res_s[0]}, 64'h06260060);
    do_job(0, 16'hFFFF, 16'hFFFF, 1); wait_idle(0);
    chk("res_ffffxffff", {32'd0, res_s[0]}, 64'hFFFE0001);
    do_job(0, 16'h0000, 16'hABCD, 1); wait_idle(0);
    chk("res_zero", {32'd0, res_s[0]}, 64'd0);
    do_job(0, 16'h1234, 16'h5678, 1); wait_idle(0);

    // Abort in RD cnt=2.
    do_job(0, 16'hBEEF, 16'h1357, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("in_rd_cnt2", {62'd0, rd_en_s[0], 1'b0} | {60'd0, rd_sel_s[0], 2'd0}, 64'h0A);
    abort_s[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_s[0] = 1'b0;
    chk("abort_idle", {61'd0, busy_s[0], wr_en_s[0], rd_en_s[0]}, 64'd0);
    repeat (12) @(negedge clk);
    chk("abort_result_kept", {32'd0, res_s[0]}, 64'h06260060);

    // Abort in IDLE is ignored.
    abort_s[0] = 1'b1;
    repeat (2) @(negedge clk);
    abort_s[0] = 1'b0;
    chk("abort_in_idle", {31'd0, busy_s[0], res_s[0]}, 64'h06260060);

    // Start pulsed while busy with new operands: ignored.
    do_job(0, 16'h0F0F, 16'h3333, 1);
    repeat (3) @(negedge clk);
    start_s[0] = 1'b1; opa[0] = 16'hAAAA; opb[0] = 16'h5555;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("start_ignored", {32'd0, res_s[0]}, 64'(32'h0F0F * 32'h3333));

    // RD_LAT=3 directed, and start+abort together in IDLE.
    do_job(1, 16'h00FF, 16'h0100, 1); wait_idle(1);
    chk("res_lat3", {32'd0, res_s[1]}, 64'h0000FF00);
    abort_s[1] = 1'b1;
    do_job(1, 16'h4321, 16'h8765, 1); wait_idle(1);

    // Random back-to-back jobs on both instances.
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 8; n++) begin
        do_job(i, 16'($urandom), 16'($urandom), 1);
        wait_idle(i);
      end

    // Reset during WR cnt=1.
    do_job(0, 16'hC0DE, 16'hFACE, 1);
    @(posedge clk);
    #1;
    chk("in_wr_cnt1", {61'd0, wr_en_s[0], wr_sel_s[0]}, 64'd5);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out",
        {busy_s[0], done_s[0], wr_en_s[0], rd_en_s[0], wr_sel_s[0], rd_sel_s[0], wr_data_s[0], res_s[0]},
        64'd0);
    for (int i = 0; i < 2; i++) begin
      sbq[i].delete();
      last_res[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_job(0, 16'h1234, 16'h5678, 1); wait_idle(0);
    chk("post_reset_res", {32'd0, res_s[0]}, 64'h06260060);

    repeat (4) @(negedge clk);
    chk("sbq0_empty", 64'(sbq[0].size()), 64'd0);
    chk("sbq1_empty", 64'(sbq[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
